// File: rtl/calc_engine.sv
// calc_engine: sequential signed arithmetic core feeding the seven-segment
// display driver. Add/sub finish in one step. Mul/div run W shift iterations
// on operand magnitudes, and the sign is applied at the end.
module calc_engine #(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [W-1:0]          a,
  input  logic [W-1:0]          b,
  output logic                  busy,
  output logic                  done,
  output logic signed [2*W-1:0] result,
  output logic                  ovf,
  output logic                  err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int CW = $clog2(W + 1);

  // Three digits on the display cover -255..255; anything outside is flagged.
  localparam logic signed [2*W-1:0] OVF_HI = (2*W)'(255);
  localparam logic signed [2*W-1:0] OVF_LO = -OVF_HI;

  logic [1:0]            state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [W-1:0]          a_q, a_d;
  logic [W-1:0]          b_q, b_d;
  logic                  sign_q, sign_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2*W-1:0]        mcand_q, mcand_d;
  logic [W-1:0]          mplr_q, mplr_d;
  logic [2*W-1:0]        acc_q, acc_d;
  logic [W-1:0]          dvd_q, dvd_d;
  logic [W:0]            rem_q, rem_d;
  logic [W:0]            dvsr_q, dvsr_d;
  logic signed [2*W-1:0] result_q, result_d;
  logic                  ovf_q, ovf_d;
  logic                  err_q, err_d;

  logic [W:0]            aExt, bExt, magA, magB;
  logic [W:0]            remShift;
  logic [2*W-1:0]        quoExt;
  logic signed [2*W-1:0] resNext;

  // Operand magnitudes, one bit wider so that -2^(W-1) becomes +2^(W-1).
  always_comb begin
    aExt = {a[W-1], a};
    bExt = {b[W-1], b};
    magA = aExt[W] ? -aExt : aExt;
    magB = bExt[W] ? -bExt : bExt;
  end

  // Final value written on the CALC->DONE edge, chosen by the captured opcode.
  always_comb begin
    quoExt  = {{W{1'b0}}, dvd_q};
    resNext = '0;
    case (op_q)
      OP_ADD:  resNext = {{W{a_q[W-1]}}, a_q} + {{W{b_q[W-1]}}, b_q};
      OP_SUB:  resNext = {{W{a_q[W-1]}}, a_q} - {{W{b_q[W-1]}}, b_q};
      OP_MUL:  resNext = sign_q ? -acc_q : acc_q;
      OP_DIV:  resNext = (b_q == '0) ? '0 : (sign_q ? -quoExt : quoExt);
      default: resNext = '0;
    endcase
  end

  // Next-state logic: capture on start, iterate while counting, publish at zero.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    remShift = {rem_q[W-1:0], dvd_q[W-1]};

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          sign_d  = a[W-1] ^ b[W-1];
          mcand_d = {{(W-1){1'b0}}, magA};
          mplr_d  = magB[W-1:0];
          acc_d   = '0;
          dvd_d   = magA[W-1:0];
          rem_d   = '0;
          dvsr_d  = magB;
          if ((op == OP_MUL) || ((op == OP_DIV) && (b != '0))) begin
            cnt_d = CW'(W);
          end else begin
            cnt_d = '0;
          end
        end
      end

      CALC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (op_q == OP_MUL) begin
            if (mplr_q[0]) begin
              acc_d = acc_q + mcand_q;
            end
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
          end else begin
            if (remShift >= dvsr_q) begin
              rem_d = remShift - dvsr_q;
              dvd_d = {dvd_q[W-2:0], 1'b1};
            end else begin
              rem_d = remShift;
              dvd_d = {dvd_q[W-2:0], 1'b0};
            end
          end
        end else begin
          state_d  = DONE;
          result_d = resNext;
          if ((op_q == OP_DIV) && (b_q == '0)) begin
            err_d = 1'b1;
            ovf_d = 1'b0;
          end else begin
            err_d = 1'b0;
            ovf_d = (resNext > OVF_HI) || (resNext < OVF_LO);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset; reset drops any partial work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      dvd_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_calc_engine.sv
// tb_calc_engine: directed and random operations on calc_engine, compared
// against a plain-integer arithmetic model of each opcode and its latency.
module tb_calc_engine;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [1:0]        op;
  logic [7:0]        a;
  logic [7:0]        b;
  logic              busy;
  logic              done;
  logic signed [15:0] result;
  logic              ovf;
  logic              err;

  int total = 0;
  int bad   = 0;
  int lastR = 0;

  calc_engine #(.W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .err    (err)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle before looking at outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One counted comparison; a mismatch is logged and counted.
  task automatic checkOutput(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Arithmetic model: what the display should show, and how many edges it takes.
  task automatic model(input int o, input int av, input int bv,
                       output int r, output int ov, output int er, output int lat);
    er  = 0;
    lat = 1;
    case (o)
      0: r = av + bv;
      1: r = av - bv;
      2: begin r = av * bv; lat = 9; end
      default: begin
        if (bv == 0) begin
          r  = 0;
          er = 1;
        end else begin
          r   = av / bv;
          lat = 9;
        end
      end
    endcase
    ov = (er == 0 && (r > 255 || r < -255)) ? 1 : 0;
  endtask

  // Issue one operation, wait for done, and compare everything it publishes.
  task automatic applyStimulus(input int o, input int av, input int bv);
    int expR, expO, expE, expLat, lat;
    model(o, av, bv, expR, expO, expE, expLat);
    op    = 2'(o);
    a     = 8'(av);
    b     = 8'(bv);
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    op    = 2'($urandom);
    checkOutput("busy_after_start", int'(busy), 1);
    checkOutput("result_held", int'(result), lastR);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
    checkOutput("latency", lat, expLat);
    checkOutput("result", int'(result), expR);
    checkOutput("ovf", int'(ovf), expO);
    checkOutput("err", int'(err), expE);
    checkOutput("busy_in_done", int'(busy), 1);
    tick();
    checkOutput("done_cleared", int'(done), 0);
    checkOutput("busy_cleared", int'(busy), 0);
    checkOutput("result_stays", int'(result), expR);
    lastR = expR;
  endtask

  // Linear sequence of directed steps followed by random operations.
  initial begin
    int expMul;
    rst_n = 1'b0;
    start = 1'b1;
    op    = 2'b00;
    a     = 8'd1;
    b     = 8'd1;
    tick();
    tick();
    start = 1'b0;
    rst_n = 1'b1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_result", int'(result), 0);
    checkOutput("reset_ovf", int'(ovf), 0);
    checkOutput("reset_err", int'(err), 0);
    lastR = 0;
    tick();

    applyStimulus(0, 100, 27);
    applyStimulus(1, 5, 20);
    applyStimulus(0, 127, 127);
    applyStimulus(1, -128, 127);
    applyStimulus(2, -12, 11);
    applyStimulus(2, 20, 20);
    applyStimulus(2, -128, -128);
    applyStimulus(3, -100, 7);
    applyStimulus(3, -128, -1);
    applyStimulus(3, 7, 0);
    applyStimulus(3, 127, -128);
    applyStimulus(2, 127, -128);

    // A start pulse while the mul is running must neither queue nor disturb it.
    expMul = 9 * -13;
    op = 2'b10; a = 8'(9); b = 8'(-13); start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    op = 2'b00; a = 8'd50; b = 8'd50; start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_ignore_k3", int'(busy), 1);
    for (int n = 4; n <= 8; n++) begin
      tick();
      checkOutput("no_early_done", int'(done), 0);
      checkOutput("held_during_mul", int'(result), lastR);
    end
    op = 2'b00; a = 8'd50; b = 8'd50; start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("mul_done_k9", int'(done), 1);
    checkOutput("mul_result", int'(result), expMul);
    checkOutput("mul_ovf", int'(ovf), 0);
    lastR = expMul;
    for (int n = 0; n < 4; n++) begin
      tick();
      checkOutput("no_second_done", int'(done), 0);
      checkOutput("no_queued_op", int'(busy), 0);
      checkOutput("mul_result_held", int'(result), expMul);
    end

    // Reset in the middle of a divide abandons it without a result.
    op = 2'b11; a = 8'(-100); b = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    checkOutput("midreset_result", int'(result), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    checkOutput("midreset_done", int'(done), 0);
    lastR = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      checkOutput("midreset_no_done", int'(done), 0);
    end
    applyStimulus(0, -3, 9);

    for (int i = 0; i < 40; i++) begin
      int ro, ra, rb;
      ro = int'($urandom_range(0, 3));
      ra = int'($urandom_range(0, 255)) - 128;
      rb = int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 9) == 0) rb = 0;
      applyStimulus(ro, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
